// File: rtl/write_s_block_pkg.sv
// Shared definitions for the S-matrix write-back stage of the IDCT.
// Holds the FSM encoding, the DPRAM base of the S results and the SRAM address helper.
package write_s_block_pkg;

  typedef enum logic [1:0] {
    S_WS_IDLE,
    S_WS_RUN,
    S_WS_FLUSH,
    S_WS_DONE
  } WRITE_S_state_type;

  localparam logic [6:0] S_RESULT_BASE = 7'd64;

  // Tag travelling alongside the one-cycle DPRAM read latency.
  typedef struct packed {
    logic       vld;
    logic [5:0] k;
  } ws_rd_tag_t;

  // Raster word address of element k of an 8x8 block; wraps mod 2^18.
  function automatic logic [17:0] ws_word_addr(input logic [17:0] base,
                                               input logic [17:0] wpr,
                                               input logic [4:0]  brow,
                                               input logic [5:0]  bcol,
                                               input logic [5:0]  k);
    logic [17:0] img_row;
    img_row = {10'd0, brow, 3'd0} + {15'd0, k[5:3]};
    return base + img_row * wpr + {10'd0, bcol, 2'd0} + {16'd0, k[2:1]};
  endfunction

endpackage

// File: rtl/write_s_block_ws_clip.sv
// Scales an S result down by 2^16 and clips it to an unsigned 8-bit pixel.
module ws_clip
  import write_s_block_pkg::*;
(
  input  logic [31:0] s_in,
  output logic [7:0]  pix
);

  logic signed [31:0] p;

  always_comb begin
    p = $signed(s_in) >>> 16;
    if (p < 0)
      pix = 8'd0;
    else if (p > 32'sd255)
      pix = 8'hFF;
    else
      pix = p[7:0];
  end

endmodule

// File: rtl/write_s_block.sv
// Drains the 64 S results from the DPRAM upper half, clips them to pixels and
// writes the 8x8 block to SRAM as 32 packed two-pixel words.
module write_s_block
  import write_s_block_pkg::*;
#(
  parameter logic [17:0] BASE_ADDR     = 18'd0,
  parameter int          WORDS_PER_ROW = 160
) (
  input  logic        CLOCK_50_I,
  input  logic        Resetn,
  input  logic        WS_start,
  output logic        WS_done,
  input  logic [5:0]  block_col,
  input  logic [4:0]  block_row,
  output logic [6:0]  read_address,
  input  logic [31:0] read_data,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n
);

  localparam logic [17:0] WPR = 18'(WORDS_PER_ROW);

  WRITE_S_state_type state_q, state_d;
  logic [5:0]  k_q, k_d;
  logic [5:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  ws_rd_tag_t  rd_q, rd_d;
  logic [7:0]  even_q, even_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_n_q, we_n_d;
  logic [7:0]  pix;

  ws_clip u_clip (.s_in(read_data), .pix(pix));

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) state_q <= S_WS_IDLE;
    else         state_q <= state_d;
  end

  // k doubles as the two-cycle flush counter once the reads are issued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WS_IDLE:  if (WS_start)     state_d = S_WS_RUN;
      S_WS_RUN:   if (k_q == 6'd63) state_d = S_WS_FLUSH;
      S_WS_FLUSH: if (k_q == 6'd1)  state_d = S_WS_DONE;
      S_WS_DONE:                    state_d = S_WS_IDLE;
      default:                      state_d = S_WS_IDLE;
    endcase
  end

  always_comb begin
    WS_done      = (state_q == S_WS_DONE);
    read_address = S_RESULT_BASE + {1'b0, k_q};
  end

  always_comb begin
    k_d   = k_q;
    col_d = col_q;
    row_d = row_q;
    case (state_q)
      S_WS_IDLE: begin
        k_d = 6'd0;
        if (WS_start) begin
          col_d = block_col;
          row_d = block_row;
        end
      end
      S_WS_RUN:   k_d = (k_q == 6'd63) ? 6'd0 : k_q + 6'd1;
      S_WS_FLUSH: k_d = (k_q == 6'd1)  ? 6'd0 : k_q + 6'd1;
      default:    k_d = 6'd0;
    endcase
  end

  // Even pixels wait in even_q; each odd pixel completes a word and fires a write.
  always_comb begin
    rd_d.vld = (state_q == S_WS_RUN);
    rd_d.k   = k_q;
    even_d   = even_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_n_d   = 1'b1;
    if (rd_q.vld) begin
      if (!rd_q.k[0]) begin
        even_d = pix;
      end else begin
        we_n_d  = 1'b0;
        wdata_d = {even_q, pix};
        addr_d  = ws_word_addr(BASE_ADDR, WPR, row_q, col_q, rd_q.k);
      end
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      k_q     <= 6'd0;
      col_q   <= 6'd0;
      row_q   <= 5'd0;
      rd_q    <= '0;
      even_q  <= 8'd0;
      addr_q  <= 18'd0;
      wdata_q <= 16'd0;
      we_n_q  <= 1'b1;
    end else begin
      k_q     <= k_d;
      col_q   <= col_d;
      row_q   <= row_d;
      rd_q    <= rd_d;
      even_q  <= even_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_n_q  <= we_n_d;
    end
  end

  assign SRAM_address    = addr_q;
  assign SRAM_write_data = wdata_q;
  assign SRAM_we_n       = we_n_q;

endmodule

// File: tb/tb_write_s_block.sv
// Bench for write_s_block: DPRAM model, write/done scoreboard, clip table, corner sequences.
module tb_write_s_block;

  logic        CLOCK_50_I = 1'b0;
  logic        Resetn = 1'b1;
  logic        WS_start = 1'b0;
  logic [5:0]  block_col = '0;
  logic [4:0]  block_row = '0;
  logic [6:0]  read_address;
  logic [31:0] read_data = '0;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        WS_done;

  write_s_block dut (
    .CLOCK_50_I(CLOCK_50_I), .Resetn(Resetn), .WS_start(WS_start), .WS_done(WS_done),
    .block_col(block_col), .block_row(block_row), .read_address(read_address),
    .read_data(read_data), .SRAM_address(SRAM_address),
    .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n)
  );

  always #10 CLOCK_50_I = ~CLOCK_50_I;

  logic [31:0] mem [128];
  always @(posedge CLOCK_50_I) read_data <= mem[read_address];

  int cyc = 0;
  always @(posedge CLOCK_50_I) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [17:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] din;
    logic [7:0]  pix;
  } clip_vec_t;

  wr_t         wr_q[$];
  int          done_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          wr_cnt = 0;
  logic [17:0] first_addr, last_addr;
  logic [15:0] cap_data [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_clip(input logic [31:0] d);
    int p;
    p = int'(d) >>> 16;
    if (p < 0) return 8'd0;
    if (p > 255) return 8'd255;
    return p[7:0];
  endfunction

  function automatic logic [17:0] exp_addr(input int col, input int row, input int i);
    int a;
    a = (row * 8 + i / 8) * 160 + col * 4 + (i % 8) / 2;
    return a[17:0];
  endfunction

  always @(negedge CLOCK_50_I) begin
    wr_t w;
    int  dc;
    if (SRAM_we_n === 1'b0) begin
      if (wr_cnt == 0) first_addr = SRAM_address;
      last_addr = SRAM_address;
      if (wr_cnt < 32) cap_data[wr_cnt] = SRAM_write_data;
      wr_cnt++;
      if (wr_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_write: got addr %0d expected no write (cycle %0d)", SRAM_address, cyc);
      end else begin
        w = wr_q.pop_front();
        chk("wr_cycle", cyc, w.cyc);
        chk("wr_addr", {14'd0, SRAM_address}, {14'd0, w.addr});
        chk("wr_data", {16'd0, SRAM_write_data}, {16'd0, w.data});
      end
    end
    if (WS_done === 1'b1) begin
      if (done_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_done: got WS_done=1 expected 0 (cycle %0d)", cyc);
      end else begin
        dc = done_q.pop_front();
        chk("done_cycle", cyc, dc);
      end
    end
  end

  // sc is the cyc value seen during cycle 1 of the block.
  task automatic push_block(input int col, input int row, input int sc);
    wr_t w;
    for (int i = 1; i < 64; i += 2) begin
      w.cyc  = sc + 2 + i;
      w.addr = exp_addr(col, row, i);
      w.data = {ref_clip(mem[64 + i - 1]), ref_clip(mem[64 + i])};
      wr_q.push_back(w);
    end
    done_q.push_back(sc + 66);
  endtask

  task automatic start_block(input int col, input int row, output int sc);
    @(negedge CLOCK_50_I);
    WS_start  = 1'b1;
    block_col = col[5:0];
    block_row = row[4:0];
    @(posedge CLOCK_50_I);
    #1;
    sc = cyc;
    push_block(col, row, sc);
    WS_start  = 1'b0;
    block_col = ~block_col;
    block_row = ~block_row;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((wr_q.size() != 0 || done_q.size() != 0) && n < limit) begin
      @(posedge CLOCK_50_I);
      n++;
    end
    if (wr_q.size() != 0 || done_q.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL timeout: got %0d writes/%0d dones pending expected 0", wr_q.size(), done_q.size());
      wr_q.delete();
      done_q.delete();
    end
    repeat (8) @(posedge CLOCK_50_I);
  endtask

  initial begin
    clip_vec_t cv[10];
    int sc;

    for (int i = 0; i < 128; i++) mem[i] = '0;
    #2 Resetn = 1'b0;
    #3;
    chk("rst_we_n", {31'd0, SRAM_we_n}, 32'd1);
    chk("rst_done", {31'd0, WS_done}, 32'd0);
    chk("rst_addr", {14'd0, SRAM_address}, 32'd0);
    chk("rst_wdata", {16'd0, SRAM_write_data}, 32'd0);
    chk("rst_rd_addr", {25'd0, read_address}, 32'd64);
    repeat (3) @(negedge CLOCK_50_I);
    Resetn = 1'b1;
    repeat (4) @(posedge CLOCK_50_I);

    // Block (0,0) sweep
    for (int i = 0; i < 64; i++) mem[64 + i] = (i * 3) << 16;
    wr_cnt = 0;
    start_block(0, 0, sc);
    drain(200);
    chk("sweep_count", wr_cnt, 32);
    chk("sweep_first_addr", {14'd0, first_addr}, 32'd0);
    chk("sweep_last_addr", {14'd0, last_addr}, 32'd1123);
    chk("sweep_word0", {16'd0, cap_data[0]}, 32'h0003);
    chk("sweep_word1", {16'd0, cap_data[1]}, 32'h0609);

    // Block (39,29) addressing
    wr_cnt = 0;
    start_block(39, 29, sc);
    drain(200);
    chk("b39_29_first", {14'd0, first_addr}, 32'd37276);
    chk("b39_29_last", {14'd0, last_addr}, 32'd38399);

    // Clip table
    cv[0] = '{32'h0012_3456, 8'd18};
    cv[1] = '{32'h0100_0000, 8'd255};
    cv[2] = '{32'hFFFF_0000, 8'd0};
    cv[3] = '{32'h00FF_FFFF, 8'd255};
    cv[4] = '{32'h8000_0000, 8'd0};
    cv[5] = '{32'h0080_0000, 8'd128};
    cv[6] = '{32'h7FFF_FFFF, 8'd255};
    cv[7] = '{32'hFFFF_FFFF, 8'd0};
    cv[8] = '{32'h0000_FFFF, 8'd0};
    cv[9] = '{32'h00FE_8000, 8'd254};
    for (int i = 0; i < 64; i++) mem[64 + i] = '0;
    for (int j = 0; j < 10; j++) mem[64 + j] = cv[j].din;
    wr_cnt = 0;
    start_block(1, 2, sc);
    drain(200);
    for (int j = 0; j < 10; j++)
      chk("clip", {24'd0, (j % 2 == 0) ? cap_data[j / 2][15:8] : cap_data[j / 2][7:0]},
          {24'd0, cv[j].pix});

    // WS_start held high: one block per 68 cycles
    for (int i = 0; i < 64; i++) mem[64 + i] = $urandom;
    wr_cnt = 0;
    @(negedge CLOCK_50_I);
    WS_start  = 1'b1;
    block_col = 6'd5;
    block_row = 5'd3;
    @(posedge CLOCK_50_I);
    #1;
    sc = cyc;
    push_block(5, 3, sc);
    push_block(5, 3, sc + 68);
    push_block(5, 3, sc + 136);
    repeat (136) @(posedge CLOCK_50_I);
    #1 WS_start = 1'b0;
    drain(200);
    chk("held_count", wr_cnt, 96);

    // Start pulse during RUN is ignored
    wr_cnt = 0;
    start_block(7, 1, sc);
    repeat (20) @(posedge CLOCK_50_I);
    @(negedge CLOCK_50_I);
    WS_start = 1'b1;
    @(negedge CLOCK_50_I);
    WS_start = 1'b0;
    drain(200);
    chk("busy_count", wr_cnt, 32);

    // Reset in cycle 30 (a write cycle)
    wr_cnt = 0;
    start_block(2, 2, sc);
    repeat (29) @(posedge CLOCK_50_I);
    #2 Resetn = 1'b0;
    #1;
    chk("mid_rst_we_n", {31'd0, SRAM_we_n}, 32'd1);
    chk("mid_rst_done", {31'd0, WS_done}, 32'd0);
    chk("mid_rst_addr", {14'd0, SRAM_address}, 32'd0);
    chk("mid_rst_wdata", {16'd0, SRAM_write_data}, 32'd0);
    chk("mid_rst_rd_addr", {25'd0, read_address}, 32'd64);
    wr_q.delete();
    done_q.delete();
    repeat (3) @(negedge CLOCK_50_I);
    Resetn = 1'b1;
    repeat (10) @(posedge CLOCK_50_I);
    chk("post_rst_writes", wr_cnt, 13);
    wr_cnt = 0;
    start_block(2, 2, sc);
    drain(200);
    chk("post_rst_count", wr_cnt, 32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
